// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU.
// Holds datapath widths, the load-byte selector encoding and the MEM/WB bundle.
package cpu_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    typedef enum logic [1:0] {
        LB_NONE = 2'b00,
        LB_LLB  = 2'b01,
        LB_LHB  = 2'b10,
        LB_RSVD = 2'b11
    } ldbyte_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dst;
        logic          regwrite;
        logic          memtoreg;
        ldbyte_t       ldbyte;
        logic [DW-1:0] alu_result;
        logic [DW-1:0] rdata;
        logic [DW-1:0] old_rd;
        logic [7:0]    imm8;
        logic          halt;
    } mem_wb_t;

    // R0 is hard-wired, and HLT never writes a register.
    function automatic logic wb_write_en(input logic regwrite, input logic halt,
                                         input logic [RW-1:0] dst);
        return regwrite & ~halt & (dst != {RW{1'b0}});
    endfunction

endpackage

// File: rtl/wb_data_mux.sv
// Combinational formation of the final register write value.
// LLB/LHB merge the immediate byte into the current destination value.
module wb_data_mux
    import cpu_pkg::*;
(
    input  ldbyte_t             ldbyte_i,
    input  logic                memtoreg_i,
    input  logic [cpu_pkg::DW-1:0] alu_result_i,
    input  logic [cpu_pkg::DW-1:0] rdata_i,
    input  logic [cpu_pkg::DW-1:0] old_rd_i,
    input  logic [7:0]          imm8_i,
    output logic [cpu_pkg::DW-1:0] data_o
);

    // Select ALU/load data or a byte merge; the reserved code behaves like none.
    always_comb begin
        data_o = alu_result_i;
        case (ldbyte_i)
            LB_LLB:  data_o = {old_rd_i[cpu_pkg::DW-1:8], imm8_i};
            LB_LHB:  data_o = {imm8_i, old_rd_i[7:0]};
            LB_NONE: data_o = memtoreg_i ? rdata_i : alu_result_i;
            default: data_o = memtoreg_i ? rdata_i : alu_result_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: drives the register-file write port,
// sequences HLT and counts retired instructions.
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int RW = cpu_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic [RW-1:0] mem_dst,
    input  logic          mem_regwrite,
    input  logic          mem_memtoreg,
    input  logic [1:0]    mem_ldbyte,
    input  logic [DW-1:0] mem_alu_result,
    input  logic [DW-1:0] mem_rdata,
    input  logic [DW-1:0] mem_old_rd,
    input  logic [7:0]    mem_imm8,
    input  logic          mem_halt,
    output logic [RW-1:0] DstReg,
    output logic          WriteReg,
    output logic [DW-1:0] DstData,
    output logic          wb_valid,
    output logic          halted,
    output logic [15:0]   retired
);

    mem_wb_t       mem_s;
    logic [DW-1:0] data_d;
    logic          wr_d;
    logic [15:0]   retired_d;

    logic [RW-1:0] dst_q;
    logic          wr_q;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          halted_q;
    logic [15:0]   retired_q;

    assign mem_s = '{
        valid:      mem_valid,
        dst:        mem_dst,
        regwrite:   mem_regwrite,
        memtoreg:   mem_memtoreg,
        ldbyte:     ldbyte_t'(mem_ldbyte),
        alu_result: mem_alu_result,
        rdata:      mem_rdata,
        old_rd:     mem_old_rd,
        imm8:       mem_imm8,
        halt:       mem_halt
    };

    wb_data_mux u_data_mux (
        .ldbyte_i     (mem_s.ldbyte),
        .memtoreg_i   (mem_s.memtoreg),
        .alu_result_i (mem_s.alu_result),
        .rdata_i      (mem_s.rdata),
        .old_rd_i     (mem_s.old_rd),
        .imm8_i       (mem_s.imm8),
        .data_o       (data_d)
    );

    assign wr_d      = wb_write_en(mem_s.regwrite, mem_s.halt, mem_s.dst);
    assign retired_d = retired_q + 16'd1;

    // Pipeline register update, priority rst > halted > stall > flush > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q     <= {RW{1'b0}};
            wr_q      <= 1'b0;
            data_q    <= {DW{1'b0}};
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= 16'd0;
        end else if (halted_q) begin
            wr_q      <= 1'b0;
        end else if (stall) begin
            wr_q      <= wr_q;
            valid_q   <= valid_q;
        end else if (flush || !mem_s.valid) begin
            // Bubble: DstReg/DstData keep their last values.
            wr_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            dst_q     <= mem_s.dst;
            wr_q      <= wr_d;
            data_q    <= data_d;
            valid_q   <= 1'b1;
            halted_q  <= mem_s.halt;
            retired_q <= retired_d;
        end
    end

    assign DstReg   = dst_q;
    assign WriteReg = wr_q;
    assign DstData  = data_q;
    assign wb_valid = valid_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed plan items, random traffic,
// and a full 65536-capture run to exercise retired-count wrap.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, mem_valid, mem_regwrite, mem_memtoreg, mem_halt;
    logic [3:0]  mem_dst;
    logic [1:0]  mem_ldbyte;
    logic [15:0] mem_alu_result, mem_rdata, mem_old_rd;
    logic [7:0]  mem_imm8;
    logic [3:0]  DstReg;
    logic        WriteReg, wb_valid, halted;
    logic [15:0] DstData, retired;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_ldbyte(mem_ldbyte), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_old_rd(mem_old_rd), .mem_imm8(mem_imm8), .mem_halt(mem_halt),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .wb_valid(wb_valid), .halted(halted), .retired(retired)
    );

    typedef struct {
        logic [3:0]  dst;
        logic        wr;
        logic [15:0] data;
        logic        valid;
        logic        halted;
        logic [15:0] retired;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT outputs after each edge against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("DstReg",   {12'd0, DstReg},   {12'd0, e.dst});
            chk("WriteReg", {15'd0, WriteReg}, {15'd0, e.wr});
            chk("DstData",  DstData,           e.data);
            chk("wb_valid", {15'd0, wb_valid}, {15'd0, e.valid});
            chk("halted",   {15'd0, halted},   {15'd0, e.halted});
            chk("retired",  retired,           e.retired);
        end
    end

    // Drive one cycle of stimulus and record what the stage must show after the edge.
    task automatic step(input bit r, input bit s, input bit f, input bit v,
                        input logic [3:0] d, input bit rw, input bit m2r,
                        input logic [1:0] lb, input logic [15:0] alu,
                        input logic [15:0] rd, input logic [15:0] old,
                        input logic [7:0] imm, input bit h);
        @(negedge clk);
        rst = r; stall = s; flush = f; mem_valid = v; mem_dst = d;
        mem_regwrite = rw; mem_memtoreg = m2r; mem_ldbyte = lb;
        mem_alu_result = alu; mem_rdata = rd; mem_old_rd = old;
        mem_imm8 = imm; mem_halt = h;
        if (r) begin
            m = '{dst: 4'd0, wr: 1'b0, data: 16'd0, valid: 1'b0, halted: 1'b0, retired: 16'd0};
        end else if (m.halted) begin
            m.wr = 1'b0;
        end else if (s) begin
            m.wr = m.wr;
        end else if (f || !v) begin
            m.valid = 1'b0;
            m.wr    = 1'b0;
        end else begin
            m.valid = 1'b1;
            m.dst   = d;
            m.wr    = rw && !h && (d != 4'd0);
            if (lb == 2'd1)      m.data = (old & 16'hFF00) | {8'd0, imm};
            else if (lb == 2'd2) m.data = ({8'd0, imm} << 8) | (old & 16'h00FF);
            else if (m2r)        m.data = rd;
            else                 m.data = alu;
            m.retired = m.retired + 16'd1;
            if (h) m.halted = 1'b1;
        end
        exp_q.push_back(m);
    endtask

    task automatic cap(input logic [3:0] d, input bit rw, input bit m2r, input logic [1:0] lb,
                       input logic [15:0] alu, input logic [15:0] rd, input logic [15:0] old,
                       input logic [7:0] imm, input bit h);
        step(1'b0, 1'b0, 1'b0, 1'b1, d, rw, m2r, lb, alu, rd, old, imm, h);
    endtask

    initial begin
        m = '{dst: 4'd0, wr: 1'b0, data: 16'd0, valid: 1'b0, halted: 1'b0, retired: 16'd0};
        rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_dst = 4'd0;
        mem_regwrite = 1'b0; mem_memtoreg = 1'b0; mem_ldbyte = 2'd0; mem_alu_result = 16'd0;
        mem_rdata = 16'd0; mem_old_rd = 16'd0; mem_imm8 = 8'd0; mem_halt = 1'b0;

        // Reset, then the directed plan items.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 8'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 2'd0, 16'h9, 16'h0, 16'h0, 8'h0, 1'b0);
        cap(4'd3, 1'b1, 1'b0, 2'd0, 16'h1234, 16'h0000, 16'h0000, 8'h00, 1'b0);
        cap(4'd4, 1'b1, 1'b1, 2'd0, 16'h0010, 16'hBEEF, 16'h0000, 8'h00, 1'b0);
        cap(4'd5, 1'b1, 1'b0, 2'd1, 16'h5555, 16'h6666, 16'hAB00, 8'hCD, 1'b0);
        cap(4'd6, 1'b1, 1'b0, 2'd2, 16'h5555, 16'h6666, 16'h00FF, 8'h12, 1'b0);
        cap(4'd0, 1'b1, 1'b0, 2'd2, 16'h5555, 16'h6666, 16'h00FF, 8'h12, 1'b0);
        cap(4'd7, 1'b1, 1'b1, 2'd3, 16'h0101, 16'h0202, 16'hFFFF, 8'hEE, 1'b0);
        cap(4'd9, 1'b0, 1'b0, 2'd0, 16'h4321, 16'h0000, 16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, (i == 1), 1'b1, 4'd2, 1'b1, 1'b0, 2'd0, 16'h7777, 16'h0, 16'h0, 8'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 2'd0, 16'h7777, 16'h0, 16'h0, 8'h0, 1'b0);
        cap(4'd8, 1'b1, 1'b0, 2'd0, 16'hAAAA, 16'h0, 16'h0, 8'h0, 1'b0);
        cap(4'd1, 1'b1, 1'b0, 2'd0, 16'hDEAD, 16'h0, 16'h0, 8'h0, 1'b1);
        for (int i = 0; i < 5; i++)
            cap(4'd10, 1'b1, 1'b0, 2'd0, 16'hC0DE, 16'h0, 16'h0, 8'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 2'd0, 16'h1, 16'h0, 16'h0, 8'h0, 1'b0);

        // Random traffic including stalls, flushes, bubbles, halts and resets.
        for (int i = 0; i < 600; i++)
            step(($urandom % 64) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
                 ($urandom % 4) != 0, 4'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 8'($urandom), ($urandom % 40) == 0);

        // Retired counter wrap: 65536 captures after reset bring it back to 0.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 8'h0, 1'b0);
        for (int i = 0; i < 65536; i++)
            cap(4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom), 8'($urandom), 1'b0);
        cap(4'd12, 1'b1, 1'b0, 2'd0, 16'h00AA, 16'h0, 16'h0, 8'h0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
